// File: rtl/pong_pkg.sv
// Shared definitions for the Pong video path: VGA 640x480@60 timing,
// game-state encodings used by the game FSM, the palette and the
// clip-safe span test used by the renderer.
package pong_pkg;

  // Horizontal timing in pixel clocks
  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;

  // Vertical timing in lines
  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  // Game-state encodings, shared with the game FSM
  localparam logic [1:0] ST_NEW_GAME = 2'd0;
  localparam logic [1:0] ST_PLAY     = 2'd1;
  localparam logic [1:0] ST_NEW_BALL = 2'd2;
  localparam logic [1:0] ST_OVER     = 2'd3;

  // Palette, {R,G,B} 4 bits each
  localparam logic [11:0] COL_BALL    = 12'hFFF;
  localparam logic [11:0] COL_PADDLE  = 12'h0F0;
  localparam logic [11:0] COL_LINE    = 12'h888;
  localparam logic [11:0] COL_BG_PLAY = 12'h000;
  localparam logic [11:0] COL_BG_OVER = 12'h400;
  localparam logic [11:0] COL_BLANK   = 12'h000;

  // Per-frame snapshot of the game inputs
  typedef struct packed {
    logic [9:0] ballX;
    logic [9:0] ballY;
    logic [9:0] paddle1;
    logic [9:0] paddle2;
    logic [1:0] state;
  } shadow_t;

  // True when start <= pos <= start+size-1. The end is formed in 11 bits so
  // an object hanging past coordinate 1023 is clipped instead of wrapping
  // around onto the low coordinates.
  function automatic logic inSpan(input logic [9:0] pos,
                                  input logic [9:0] start,
                                  input logic [10:0] size);
    logic [10:0] endExcl;
    endExcl = {1'b0, start} + size;
    return ({1'b0, pos} >= {1'b0, start}) && ({1'b0, pos} < endExcl);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel/line counters for the VGA raster plus the raw (unregistered)
// sync, visible-area and frame-start decode derived from them.
module vga_timing
  import pong_pkg::*;
#(
  parameter int H_VISIBLE = pong_pkg::H_VIS,
  parameter int H_FRONT   = pong_pkg::H_FP,
  parameter int H_SYNCW   = pong_pkg::H_SYNC,
  parameter int H_BACK    = pong_pkg::H_BP,
  parameter int V_VISIBLE = pong_pkg::V_VIS,
  parameter int V_FRONT   = pong_pkg::V_FP,
  parameter int V_SYNCW   = pong_pkg::V_SYNC,
  parameter int V_BACK    = pong_pkg::V_BP
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       pix_en_i,
  output logic [9:0] hcnt_o,
  output logic [9:0] vcnt_o,
  output logic       hsyncRaw_o,
  output logic       vsyncRaw_o,
  output logic       visible_o,
  output logic       frameStart_o
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNCW + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNCW + V_BACK;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNCW);
  localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNCW);
  localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);

  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;

  // Advance the raster one pixel per strobe; the line counter steps on wrap
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pix_en_i) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
    end
  end

  // Counter registers; reset restarts the raster at pixel (0,0)
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign hcnt_o       = hcnt_q;
  assign vcnt_o       = vcnt_q;
  assign hsyncRaw_o   = !((hcnt_q >= H_SYNC_START) && (hcnt_q < H_SYNC_END));
  assign vsyncRaw_o   = !((vcnt_q >= V_SYNC_START) && (vcnt_q < V_SYNC_END));
  assign visible_o    = (hcnt_q < H_VIS_END) && (vcnt_q < V_VIS_END);
  assign frameStart_o = (hcnt_q == '0) && (vcnt_q == V_VIS_END);

endmodule

// File: rtl/pong_vga_renderer.sv
// Pong renderer: snapshots the game state once per frame at the start of
// vertical blanking, hit-tests ball/paddles/centre line against the raster
// and drives registered sync and colour one pixel behind the counters.
module pong_vga_renderer
  import pong_pkg::*;
#(
  parameter int PADDLE_H  = 64,
  parameter int BALL_S    = 8,
  parameter int P1_X      = 16,
  parameter int P2_X      = 616,
  parameter int H_VISIBLE = pong_pkg::H_VIS,
  parameter int H_FRONT   = pong_pkg::H_FP,
  parameter int H_SYNCW   = pong_pkg::H_SYNC,
  parameter int H_BACK    = pong_pkg::H_BP,
  parameter int V_VISIBLE = pong_pkg::V_VIS,
  parameter int V_FRONT   = pong_pkg::V_FP,
  parameter int V_SYNCW   = pong_pkg::V_SYNC,
  parameter int V_BACK    = pong_pkg::V_BP
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        pix_en_i,
  input  logic [1:0]  game_state_i,
  input  logic [9:0]  ball_x_i,
  input  logic [9:0]  ball_y_i,
  input  logic [9:0]  paddle1_i,
  input  logic [9:0]  paddle2_i,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic [11:0] rgb_o,
  output logic        frame_tick_o
);

  localparam logic [9:0]  P1_LEFT   = 10'(P1_X);
  localparam logic [9:0]  P2_LEFT   = 10'(P2_X);
  localparam logic [10:0] PADDLE_W  = 11'd8;
  localparam logic [10:0] PADDLE_HT = 11'(PADDLE_H);
  localparam logic [10:0] BALL_SZ   = 11'(BALL_S);
  localparam logic [9:0]  CENTRE_L  = 10'(H_VISIBLE / 2 - 1);
  localparam logic [9:0]  CENTRE_R  = 10'(H_VISIBLE / 2);

  logic [9:0] hcnt, vcnt;
  logic       hsyncRaw, vsyncRaw, visible, frameStart;

  vga_timing #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNCW   (H_SYNCW),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNCW   (V_SYNCW),
    .V_BACK    (V_BACK)
  ) uTiming (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .pix_en_i     (pix_en_i),
    .hcnt_o       (hcnt),
    .vcnt_o       (vcnt),
    .hsyncRaw_o   (hsyncRaw),
    .vsyncRaw_o   (vsyncRaw),
    .visible_o    (visible),
    .frameStart_o (frameStart)
  );

  shadow_t     shadow_q, shadow_d;
  logic        frameTick_q, frameTick_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic [11:0] rgb_q, rgb_d;

  logic        ballHit, paddleHit, lineHit;
  logic [11:0] background, pixelColour;

  // Snapshot the game inputs once per frame so mid-frame moves never tear
  always_comb begin
    shadow_d    = shadow_q;
    frameTick_d = 1'b0;
    if (pix_en_i && frameStart) begin
      shadow_d.ballX   = ball_x_i;
      shadow_d.ballY   = ball_y_i;
      shadow_d.paddle1 = paddle1_i;
      shadow_d.paddle2 = paddle2_i;
      shadow_d.state   = game_state_i;
      frameTick_d      = 1'b1;
    end
  end

  // Hit-test the current raster position and resolve colour by priority
  always_comb begin
    ballHit = (shadow_q.state != ST_NEW_GAME)
              && inSpan(hcnt, shadow_q.ballX, BALL_SZ)
              && inSpan(vcnt, shadow_q.ballY, BALL_SZ);
    paddleHit = (inSpan(hcnt, P1_LEFT, PADDLE_W) && inSpan(vcnt, shadow_q.paddle1, PADDLE_HT))
             || (inSpan(hcnt, P2_LEFT, PADDLE_W) && inSpan(vcnt, shadow_q.paddle2, PADDLE_HT));
    lineHit = ((hcnt == CENTRE_L) || (hcnt == CENTRE_R)) && !vcnt[3];
    background = (shadow_q.state == ST_OVER) ? COL_BG_OVER : COL_BG_PLAY;
    if (!visible) begin
      pixelColour = COL_BLANK;
    end else if (ballHit) begin
      pixelColour = COL_BALL;
    end else if (paddleHit) begin
      pixelColour = COL_PADDLE;
    end else if (lineHit) begin
      pixelColour = COL_LINE;
    end else begin
      pixelColour = background;
    end
  end

  // Output stage follows the counters by one strobe and holds otherwise
  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    rgb_d   = rgb_q;
    if (pix_en_i) begin
      hsync_d = hsyncRaw;
      vsync_d = vsyncRaw;
      rgb_d   = pixelColour;
    end
  end

  // State registers; reset parks syncs inactive and the snapshot at new_game
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      shadow_q    <= '{ballX: '0, ballY: '0, paddle1: '0, paddle2: '0, state: ST_NEW_GAME};
      frameTick_q <= 1'b0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      rgb_q       <= COL_BLANK;
    end else begin
      shadow_q    <= shadow_d;
      frameTick_q <= frameTick_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      rgb_q       <= rgb_d;
    end
  end

  assign hsync_o      = hsync_q;
  assign vsync_o      = vsync_q;
  assign rgb_o        = rgb_q;
  assign frame_tick_o = frameTick_q;

endmodule

// File: tb/tb_pong_vga_renderer.sv
// Testbench for pong_vga_renderer. Uses a shrunken raster so many frames fit
// in a short run; a pixel-level model of the picture rules predicts every
// output on every clock, and a table of hand-worked pixels pins the model.
module tb_pong_vga_renderer;

  localparam int H_VIS = 64, H_FP = 4, H_SYNC = 12, H_BP = 20;
  localparam int V_VIS = 40, V_FP = 3, V_SYNC = 2, V_BP = 15;
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int PADDLE_H = 16, BALL_S = 4, P1_X = 4, P2_X = 52;
  localparam int MAX_CYCLES = 90000;
  localparam int MAX_PROBES = 32;

  logic        clk = 1'b0;
  logic        rstN;
  logic        pixEn;
  logic [1:0]  gameState;
  logic [9:0]  ballX, ballY, paddle1, paddle2;
  logic        hsync, vsync, frameTick;
  logic [11:0] rgb;

  always #5 clk = ~clk;

  pong_vga_renderer #(
    .PADDLE_H (PADDLE_H), .BALL_S (BALL_S), .P1_X (P1_X), .P2_X (P2_X),
    .H_VISIBLE (H_VIS), .H_FRONT (H_FP), .H_SYNCW (H_SYNC), .H_BACK (H_BP),
    .V_VISIBLE (V_VIS), .V_FRONT (V_FP), .V_SYNCW (V_SYNC), .V_BACK (V_BP)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rstN),
    .pix_en_i     (pixEn),
    .game_state_i (gameState),
    .ball_x_i     (ballX),
    .ball_y_i     (ballY),
    .paddle1_i    (paddle1),
    .paddle2_i    (paddle2),
    .hsync_o      (hsync),
    .vsync_o      (vsync),
    .rgb_o        (rgb),
    .frame_tick_o (frameTick)
  );

  int assertCount = 0;
  int failCount = 0;
  int cycles = 0;

  // Model state: raster position, frame snapshot and predicted outputs
  int mh = 0, mv = 0;
  int sBx = 0, sBy = 0, sP1 = 0, sP2 = 0, sState = 0;
  logic        eHs = 1'b1, eVs = 1'b1, eTick = 1'b0;
  logic [11:0] eRgb = 12'h000;
  int outX = 0, outY = 0;
  bit newPixel = 0;
  int latchCount = 0;
  int postResetTicks = 0;
  bit midResetDone = 0;
  bit midResetNow = 0;

  // Scenes presented during blanking, one per latch
  int scBx[8], scBy[8], scP1[8], scP2[8], scSt[8];

  // Hand-worked pixels: scene index, x, y, required colour
  int prScene[MAX_PROBES], prX[MAX_PROBES], prY[MAX_PROBES];
  logic [11:0] prRgb[MAX_PROBES];
  bit prHit[MAX_PROBES];
  int nProbes = 0;

  task automatic addProbe(input int sc, input int x, input int y, input logic [11:0] c);
    prScene[nProbes] = sc; prX[nProbes] = x; prY[nProbes] = y;
    prRgb[nProbes] = c; prHit[nProbes] = 0;
    nProbes++;
  endtask

  task automatic setScene(input int i, input int bx, input int by, input int p1,
                          input int p2, input int st);
    scBx[i] = bx; scBy[i] = by; scP1[i] = p1; scP2[i] = p2; scSt[i] = st;
  endtask

  task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s at cycle %0d: got %03h, expected %03h", name, cycles, act, exp);
    end
  endtask

  // Colour of pixel (x,y) from the picture rules and the current snapshot
  function automatic logic [11:0] refPixel(input int x, input int y);
    if (x >= H_VIS || y >= V_VIS) return 12'h000;
    if (sState != 0 && x >= sBx && x < sBx + BALL_S && y >= sBy && y < sBy + BALL_S)
      return 12'hFFF;
    if (x >= P1_X && x < P1_X + 8 && y >= sP1 && y < sP1 + PADDLE_H) return 12'h0F0;
    if (x >= P2_X && x < P2_X + 8 && y >= sP2 && y < sP2 + PADDLE_H) return 12'h0F0;
    if ((x == H_VIS / 2 - 1 || x == H_VIS / 2) && ((y / 8) % 2 == 0)) return 12'h888;
    return (sState == 3) ? 12'h400 : 12'h000;
  endfunction

  // Account for the clock edge just passed, using the inputs it sampled
  task automatic modelStep();
    newPixel = 0;
    if (!rstN) begin
      mh = 0; mv = 0;
      eHs = 1'b1; eVs = 1'b1; eRgb = 12'h000; eTick = 1'b0;
      sBx = 0; sBy = 0; sP1 = 0; sP2 = 0; sState = 0;
    end else begin
      eTick = pixEn && mh == 0 && mv == V_VIS;
      if (pixEn) begin
        eHs = !(mh >= H_VIS + H_FP && mh < H_VIS + H_FP + H_SYNC);
        eVs = !(mv >= V_VIS + V_FP && mv < V_VIS + V_FP + V_SYNC);
        eRgb = refPixel(mh, mv);
        outX = mh; outY = mv; newPixel = 1;
        if (eTick) begin
          sBx = int'(ballX); sBy = int'(ballY); sP1 = int'(paddle1);
          sP2 = int'(paddle2); sState = int'(gameState);
          latchCount++;
          if (midResetDone) postResetTicks++;
        end
        mh = (mh + 1) % H_TOT;
        if (mh == 0) mv = (mv + 1) % V_TOT;
      end
    end
  endtask

  // One clock: advance the model, compare all outputs, visit the probe table
  task automatic cycle();
    @(negedge clk);
    cycles++;
    modelStep();
    checkOutput("hsync", 12'(hsync), 12'(eHs));
    checkOutput("vsync", 12'(vsync), 12'(eVs));
    checkOutput("rgb", rgb, eRgb);
    checkOutput("frame_tick", 12'(frameTick), 12'(eTick));
    if (newPixel && rstN) begin
      for (int i = 0; i < nProbes; i++) begin
        if (!prHit[i] && prScene[i] == latchCount - 1 && prX[i] == outX && prY[i] == outY) begin
          prHit[i] = 1;
          checkOutput($sformatf("probe scene%0d pixel(%0d,%0d)", prScene[i], prX[i], prY[i]),
                      rgb, prRgb[i]);
        end
      end
    end
  endtask

  // Drive the next cycle: random strobe, scene during blanking, junk while drawing
  task automatic applyStimulus();
    pixEn = ($urandom_range(7) != 0);
    rstN = 1'b1;
    midResetNow = 0;
    if (!midResetDone && latchCount == 6 && mh == 30 && mv == 10) begin
      rstN = 1'b0;
      midResetDone = 1;
      midResetNow = 1;
    end
    if (mv >= V_VIS) begin
      ballX = 10'(scBx[latchCount % 8]);
      ballY = 10'(scBy[latchCount % 8]);
      paddle1 = 10'(scP1[latchCount % 8]);
      paddle2 = 10'(scP2[latchCount % 8]);
      gameState = 2'(scSt[latchCount % 8]);
    end else if ($urandom_range(15) == 0) begin
      ballX = 10'($urandom); ballY = 10'($urandom);
      paddle1 = 10'($urandom); paddle2 = 10'($urandom);
      gameState = 2'($urandom);
    end
  endtask

  task automatic finishRun();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  endtask

  initial begin
    int tailCycles;
    setScene(0, 10, 20, 5, 30, 1);
    setScene(1, 40, 8, 1020, 0, 3);
    setScene(2, 10, 20, 100, 100, 0);
    setScene(3, 1022, 36, 700, 700, 1);
    setScene(4, 60, 38, 0, 39, 2);
    for (int i = 5; i < 8; i++)
      setScene(i, $urandom_range(70), $urandom_range(45), $urandom_range(50),
               $urandom_range(50), $urandom_range(3));

    addProbe(0, 10, 20, 12'hFFF);
    addProbe(0, 13, 23, 12'hFFF);
    addProbe(0, 14, 20, 12'h000);
    addProbe(0, 9, 20, 12'h0F0);
    addProbe(0, 10, 24, 12'h000);
    addProbe(0, 31, 0, 12'h888);
    addProbe(0, 32, 15, 12'h000);
    addProbe(0, 31, 16, 12'h888);
    addProbe(0, 52, 39, 12'h0F0);
    addProbe(1, 40, 8, 12'hFFF);
    addProbe(1, 43, 11, 12'hFFF);
    addProbe(1, 4, 0, 12'h400);
    addProbe(1, 52, 0, 12'h0F0);
    addProbe(1, 20, 30, 12'h400);
    addProbe(1, 31, 8, 12'h400);
    addProbe(2, 10, 20, 12'h000);
    addProbe(2, 31, 0, 12'h888);
    addProbe(3, 0, 36, 12'h000);
    addProbe(3, 1, 37, 12'h000);
    addProbe(4, 63, 39, 12'hFFF);
    addProbe(4, 59, 38, 12'h000);
    addProbe(4, 59, 39, 12'h0F0);

    rstN = 1'b0; pixEn = 1'b0; gameState = 2'd1;
    ballX = 10'd5; ballY = 10'd5; paddle1 = 10'd5; paddle2 = 10'd5;
    for (int i = 0; i < 3; i++) begin
      pixEn = $urandom_range(1) != 0;
      cycle();
    end
    checkOutput("reset hsync", 12'(hsync), 12'h001);
    checkOutput("reset vsync", 12'(vsync), 12'h001);
    checkOutput("reset rgb", rgb, 12'h000);
    checkOutput("reset frame_tick", 12'(frameTick), 12'h000);

    tailCycles = 0;
    while (cycles < MAX_CYCLES && tailCycles < 300) begin
      applyStimulus();
      cycle();
      if (midResetNow) begin
        checkOutput("mid-reset hsync", 12'(hsync), 12'h001);
        checkOutput("mid-reset vsync", 12'(vsync), 12'h001);
        checkOutput("mid-reset rgb", rgb, 12'h000);
        checkOutput("mid-reset frame_tick", 12'(frameTick), 12'h000);
      end
      if (postResetTicks > 0) tailCycles++;
      if (failCount > 40) begin
        $display("[TB] FAIL too many errors, stopping early at cycle %0d", cycles);
        finishRun();
      end
    end

    assertCount++;
    if (cycles >= MAX_CYCLES) begin
      failCount++;
      $display("[TB] FAIL timeout: frame_tick after mid-frame reset, got %0d ticks, expected 1",
               postResetTicks);
    end
    for (int i = 0; i < nProbes; i++) begin
      if (!prHit[i]) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL probe scene%0d pixel(%0d,%0d) never drawn, expected %03h",
                 prScene[i], prX[i], prY[i], prRgb[i]);
      end
    end
    finishRun();
  end

endmodule
